// File: rtl/gc_filter_n_if.sv
// Sensor/actuator bundle for gc_filter_n: control inputs from the front-end,
// filtered actuator, state and activation count back to the driver side.
interface gc_filter_n_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             Start;
  logic [N-1:0]     Sensor;
  logic             ClrCount;
  logic             Actuator;
  logic [1:0]       State;
  logic [CNT_W-1:0] Count;

  modport master (
    output Start, Sensor, ClrCount,
    input  Actuator, State, Count
  );

  modport slave (
    input  Start, Sensor, ClrCount,
    output Actuator, State, Count
  );
endinterface

// File: rtl/gc_filter_n.sv
// Threshold-voting C-element filter: N sensors plus a Start gate drive one
// actuator through abortable set/clear hold timers, with a saturating rise count.
module gc_filter_n #(
  parameter int N          = 4,
  parameter int SET_THRESH = 4,
  parameter int CLR_THRESH = 0,
  parameter int SET_DELAY  = 5,
  parameter int CLR_DELAY  = 5,
  parameter int CNT_W      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  gc_filter_n_if.slave  bus
);

  localparam int POP_W = $clog2(N + 1);
  localparam int MAX_D = (SET_DELAY > CLR_DELAY) ? SET_DELAY : CLR_DELAY;
  localparam int TMR_W = $clog2(MAX_D + 1);

  // Timer value on the edge that completes a countdown (timer+1 == DELAY).
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SET_DELAY - 1);
  localparam logic [TMR_W-1:0] CLR_LAST = TMR_W'(CLR_DELAY - 1);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    RISING  = 2'd1,
    HIGH    = 2'd2,
    FALLING = 2'd3
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             actuator;
  logic [CNT_W-1:0] count;
  logic [POP_W-1:0] pop;
  logic             set_cond;
  logic             clr_cond;

  // NOTE: combinational accumulation uses blocking '=' with a default first,
  // so every path assigns pop and no latch is inferred.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + POP_W'(bus.Sensor[i]);
    end
  end

  // Opposite Start polarities keep the two conditions mutually exclusive.
  assign set_cond =  bus.Start && (pop >= POP_W'(SET_THRESH));
  assign clr_cond = !bus.Start && (pop <= POP_W'(CLR_THRESH));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking '<=' only; the later ClrCount
  // assignment deliberately overrides an increment made earlier in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOW;
      timer    <= '0;
      actuator <= 1'b0;
      count    <= '0;
    end else begin
      unique case (state)
        LOW: begin
          if (set_cond && SET_DELAY == 1) begin
            state    <= HIGH;
            actuator <= 1'b1;
            count    <= sat_inc(count);
          end else if (set_cond) begin
            state <= RISING;
            timer <= TMR_W'(1);
          end
        end
        RISING: begin
          if (!set_cond) begin
            state <= LOW;
            timer <= '0;
          end else if (timer == SET_LAST) begin
            state    <= HIGH;
            timer    <= '0;
            actuator <= 1'b1;
            count    <= sat_inc(count);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HIGH: begin
          if (clr_cond && CLR_DELAY == 1) begin
            state    <= LOW;
            actuator <= 1'b0;
          end else if (clr_cond) begin
            state <= FALLING;
            timer <= TMR_W'(1);
          end
        end
        FALLING: begin
          if (!clr_cond) begin
            state <= HIGH;
            timer <= '0;
          end else if (timer == CLR_LAST) begin
            state    <= LOW;
            timer    <= '0;
            actuator <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state    <= LOW;
          timer    <= '0;
          actuator <= 1'b0;
        end
      endcase

      if (bus.ClrCount) begin
        count <= '0;
      end
    end
  end

  assign bus.Actuator = actuator;
  assign bus.State    = state;
  assign bus.Count    = count;

endmodule

// File: tb/tb_gc_filter_n.sv
// Bench for gc_filter_n: three parameterisations share one directed stimulus and
// are checked every cycle against a run-length model, plus hand-computed spot checks.
module tb_gc_filter_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] sensor = 4'h0;
  logic       clr_count = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // a: defaults; b: thresholds 3/1; c: 2-bit counter with short delays.
  gc_filter_n_if #(.N(4), .CNT_W(8)) bus_a ();
  gc_filter_n_if #(.N(4), .CNT_W(8)) bus_b ();
  gc_filter_n_if #(.N(4), .CNT_W(2)) bus_c ();

  assign bus_a.Start = start;  assign bus_a.Sensor = sensor;  assign bus_a.ClrCount = clr_count;
  assign bus_b.Start = start;  assign bus_b.Sensor = sensor;  assign bus_b.ClrCount = clr_count;
  assign bus_c.Start = start;  assign bus_c.Sensor = sensor;  assign bus_c.ClrCount = clr_count;

  gc_filter_n #(.N(4), .SET_THRESH(4), .CLR_THRESH(0), .SET_DELAY(5), .CLR_DELAY(5), .CNT_W(8))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  gc_filter_n #(.N(4), .SET_THRESH(3), .CLR_THRESH(1), .SET_DELAY(5), .CLR_DELAY(5), .CNT_W(8))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  gc_filter_n #(.N(4), .SET_THRESH(4), .CLR_THRESH(0), .SET_DELAY(1), .CLR_DELAY(2), .CNT_W(2))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  // Model: the actuator level plus how many consecutive edges the condition
  // that would flip it has held so far.
  typedef struct {
    bit act;
    int run;
    int cnt;
  } model_t;

  model_t ma, mb, mc;

  function automatic model_t step(model_t s, bit st, int pop, bit clr,
                                  int set_th, int clr_th, int set_d, int clr_d, int cnt_max);
    model_t n = s;
    bit cond = s.act ? (!st && pop <= clr_th) : (st && pop >= set_th);
    bit rise = 1'b0;
    if (cond) begin
      n.run = s.run + 1;
      if (!s.act && n.run == set_d) begin
        n.act = 1'b1; n.run = 0; rise = 1'b1;
      end else if (s.act && n.run == clr_d) begin
        n.act = 1'b0; n.run = 0;
      end
    end else begin
      n.run = 0;
    end
    if (clr) n.cnt = 0;
    else if (rise && n.cnt < cnt_max) n.cnt = n.cnt + 1;
    return n;
  endfunction

  function automatic int model_state(model_t s);
    if (s.act) return (s.run > 0) ? 3 : 2;
    return (s.run > 0) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{act: 1'b0, run: 0, cnt: 0};
      mb <= '{act: 1'b0, run: 0, cnt: 0};
      mc <= '{act: 1'b0, run: 0, cnt: 0};
    end else begin
      ma <= step(ma, start, $countones(sensor), clr_count, 4, 0, 5, 5, 255);
      mb <= step(mb, start, $countones(sensor), clr_count, 3, 1, 5, 5, 255);
      mc <= step(mc, start, $countones(sensor), clr_count, 4, 0, 1, 2, 3);
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    check("a_state", int'(bus_a.State),    model_state(ma));
    check("a_act",   int'(bus_a.Actuator), int'(ma.act));
    check("a_count", int'(bus_a.Count),    ma.cnt);
    check("b_state", int'(bus_b.State),    model_state(mb));
    check("b_act",   int'(bus_b.Actuator), int'(mb.act));
    check("b_count", int'(bus_b.Count),    mb.cnt);
    check("c_state", int'(bus_c.State),    model_state(mc));
    check("c_act",   int'(bus_c.Actuator), int'(mc.act));
    check("c_count", int'(bus_c.Count),    mc.cnt);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit st, input logic [3:0] sen);
    start  = st;
    sensor = sen;
  endtask

  initial begin
    // Reset with random inputs, then idle.
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      start = 1'($urandom); sensor = 4'($urandom); clr_count = 1'($urandom);
    end
    check("rst_state", int'(bus_a.State), 0);
    check("rst_act",   int'(bus_a.Actuator), 0);
    check("rst_count", int'(bus_a.Count), 0);
    drive(1'b0, 4'h0);
    clr_count = 1'b0;
    rst_n = 1'b1;
    edges(20);
    check("idle_state", int'(bus_a.State), 0);
    check("idle_act",   int'(bus_a.Actuator), 0);

    // Nominal set then clear.
    drive(1'b1, 4'hF);
    edges(1);
    check("set_e1_state", int'(bus_a.State), 1);
    check("c_set_delay1", int'(bus_c.State), 2);
    edges(4);
    check("set_e5_act",   int'(bus_a.Actuator), 1);
    check("set_e5_state", int'(bus_a.State), 2);
    check("set_e5_count", int'(bus_a.Count), 1);
    drive(1'b0, 4'h0);
    edges(1);
    check("clr_e1_state", int'(bus_a.State), 3);
    edges(4);
    check("clr_e5_act",   int'(bus_a.Actuator), 0);
    check("clr_e5_state", int'(bus_a.State), 0);

    // Abort: one edge below threshold restarts the countdown.
    drive(1'b1, 4'hF);
    edges(3);
    check("abort_pre", int'(bus_a.State), 1);
    drive(1'b1, 4'h7);
    edges(1);
    check("abort_state", int'(bus_a.State), 0);
    check("abort_act",   int'(bus_a.Actuator), 0);
    drive(1'b1, 4'hF);
    edges(4);
    check("restart_e4_act", int'(bus_a.Actuator), 0);
    edges(1);
    check("restart_e5_act", int'(bus_a.Actuator), 1);
    check("restart_count",  int'(bus_a.Count), 2);

    // Hysteresis on the 3/1 instance.
    drive(1'b0, 4'h3);
    edges(30);
    check("hyst_hold_state", int'(bus_b.State), 2);
    check("hyst_hold_act",   int'(bus_b.Actuator), 1);
    drive(1'b0, 4'h1);
    edges(4);
    check("hyst_fall_e4", int'(bus_b.State), 3);
    edges(1);
    check("hyst_fall_act", int'(bus_b.Actuator), 0);
    drive(1'b1, 4'h3);
    edges(10);
    check("hyst_noset_state", int'(bus_b.State), 0);
    check("hyst_a_high",      int'(bus_a.State), 2);

    // Counter saturation and ClrCount priority on the 2-bit instance.
    repeat (3) begin
      drive(1'b0, 4'h0);
      edges(2);
      drive(1'b1, 4'hF);
      edges(1);
    end
    check("sat_count", int'(bus_c.Count), 3);
    drive(1'b0, 4'h0);
    edges(2);
    drive(1'b1, 4'hF);
    clr_count = 1'b1;
    edges(1);
    clr_count = 1'b0;
    check("clr_win_act",   int'(bus_c.Actuator), 1);
    check("clr_win_count", int'(bus_c.Count), 0);

    // Asynchronous reset in the middle of a set countdown.
    drive(1'b0, 4'h0);
    edges(6);
    check("pre_async_low", int'(bus_a.State), 0);
    drive(1'b1, 4'hF);
    edges(3);
    check("pre_async_rising", int'(bus_a.State), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_state",   int'(bus_a.State), 0);
    check("async_c_act",   int'(bus_c.Actuator), 0);
    check("async_c_count", int'(bus_c.Count), 0);
    edges(1);
    rst_n = 1'b1;
    edges(4);
    check("post_rst_e4_state", int'(bus_a.State), 1);
    check("post_rst_e4_act",   int'(bus_a.Actuator), 0);
    edges(1);
    check("post_rst_e5_act",   int'(bus_a.Actuator), 1);
    check("post_rst_count",    int'(bus_a.Count), 1);

    edges(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gc_filter_n.md
# gc_filter_n

Clocked, parametrised successor to the two-input genetic C-element sensor/filter. It drives a single `Actuator` from `N` sensor channels and a `Start` gate, with threshold voting on the sensors and programmable set/clear hold times in clock cycles. Unlike the earlier block, a hold countdown aborts if its condition drops before expiry. The block sits between the sensor front-end and the actuator driver in the synthesis test designs. It also reports its filter state and keeps a saturating count of activations.

## Interface
Parameters:
- `N`, 4: number of sensor channels, ≥1
- `SET_THRESH`, 4: minimum number of high sensors for the set condition, 1..N
- `CLR_THRESH`, 0: maximum number of high sensors for the clear condition, 0..SET_THRESH-1
- `SET_DELAY`, 5: consecutive cycles the set condition must hold, ≥1
- `CLR_DELAY`, 5: consecutive cycles the clear condition must hold, ≥1
- `CNT_W`, 8: width of the activation counter

Ports:
- `clk`, input, 1: single clock, rising edge
- `rst_n`, input, 1: asynchronous, active-low reset
- `Start`, input, 1: enable gate
- `Sensor`, input, N: sensor channels
- `ClrCount`, input, 1: synchronous clear of `Count`
- `Actuator`, output, 1: filtered output (registered)
- `State`, output, 2: FSM state encoding, LOW=0, RISING=1, HIGH=2, FALLING=3
- `Count`, output, CNT_W: number of Actuator 0→1 transitions, saturating

All inputs are synchronous to `clk`. Synchronisation is upstream's responsibility.

## Operation
- `pop` is the combinational popcount of `Sensor`, computed at $clog2(N+1) bits.
- Set condition: `Start==1 && pop>=SET_THRESH`.
- Clear condition: `Start==0 && pop<=CLR_THRESH`.
- The two conditions are mutually exclusive because they require opposite `Start` values.
- The hold timer is $clog2(max(SET_DELAY,CLR_DELAY)+1) bits wide.

FSM transitions, evaluated at each rising edge:
- LOW:
  - set condition and SET_DELAY==1 → HIGH
  - set condition otherwise → RISING, timer=1
  - else stay in LOW
- RISING:
  - set condition false → LOW, timer=0 (abort)
  - else if timer+1==SET_DELAY → HIGH, timer=0
  - else timer++
- HIGH:
  - clear condition and CLR_DELAY==1 → LOW
  - clear condition otherwise → FALLING, timer=1
  - else stay in HIGH
- FALLING:
  - clear condition false → HIGH, timer=0 (abort)
  - else if timer+1==CLR_DELAY → LOW, timer=0
  - else timer++

Outputs and counter:
- `Actuator` is 1 exactly in HIGH and FALLING. It is registered alongside `State`, with no combinational path from inputs.
- Inputs that satisfy neither condition (e.g. Start=1 with a mid-range popcount) hold LOW or HIGH indefinitely. This is the C-element hysteresis.
- `Count` increments on every edge where the next state is HIGH and the current state is LOW or RISING.
- `Count` saturates at 2^CNT_W−1.
- When `ClrCount` and an increment occur on the same edge, `ClrCount` wins and `Count` becomes 0.

## Timing
- Reset (`rst_n`=0, asynchronous, including mid-countdown): State=LOW, timer=0, Actuator=0, Count=0. These values hold while `rst_n` is low.
- Leaving reset: the first evaluating edge is the first rising `clk` after `rst_n` deasserts.
- Set latency: if the set condition is sampled true on SET_DELAY consecutive edges, Actuator is 1 after the SET_DELAY-th edge.
  - Example: with SET_DELAY=5, the condition is true at edges e1..e5 and Actuator rises after e5.
- Clear latency is symmetric, using CLR_DELAY.
- A single sampled edge with the condition false during RISING or FALLING restarts the full delay from zero.
- `Count` updates on the same edge as the Actuator rise.

## Test plan
- Reset and idle: rst_n=0 for 3 cycles with random inputs → Actuator=0, State=0, Count=0. After release with Start=0 and Sensor=0, everything stays unchanged for 20 cycles.
- Nominal set/clear (defaults):
  - Start=1, Sensor=4'hF held → State=1 after edge 1, Actuator=1 and State=2 after edge 5, Count=1.
  - Then Start=0, Sensor=0 held → State=3 after 1 edge, Actuator=0 after 5 edges.
- Abort: Start=1, Sensor=4'hF for 3 edges, then Sensor=4'h7 for 1 edge → State returns to 0 and Actuator stays 0.
  - Restoring 4'hF then needs 5 more edges before Actuator=1.
- Hysteresis/threshold with SET_THRESH=3, CLR_THRESH=1:
  - Sensor=4'h3 with Start=1 → no set.
  - From HIGH, Start=0 with Sensor=4'h3 → stays HIGH indefinitely.
  - Sensor=4'h1 → falls after CLR_DELAY.
- Counter with CNT_W=2: 5 activations → Count=3 (saturated).
  - ClrCount asserted on the edge of a 6th activation → Count=0.
- Async reset mid-RISING: drop rst_n between edges 3 and 4 of a set countdown → State=0 immediately, without waiting for a clock edge.
  - After release, the full 5 edges are needed before Actuator=1.
